log_capture_ctrl: RTL and testbench

Sequencer for the block-RAM sample logger. On a start command from the register file it waits a settling delay, then writes one equalizer or tap sample per rate strobe into consecutive RAM addresses until the RAM is full or a stop is issued. It also gates processor readback so the RAM is only read while no capture is running. It sits between reg_file, qpsk_comm_sys (rate strobes) and block_ram_control.

---
 rtl/log_pkg.sv | 21 ++
 rtl/log_rd_gate.sv | 38 +++
 rtl/log_capture_ctrl.sv | 140 ++++++++++++++
 tb/tb_log_capture_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/log_pkg.sv
// Shared definitions for the block-RAM sample logger: state codes,
// selector field layout and default sizing.
package log_pkg;

    localparam int RAM_DEPTH_DEF = 32768;
    localparam int N_DELAY_DEF   = 250;
    localparam int NBT_SEL_DEF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // The MSB of the data selector chooses between the two rate strobes.
    function automatic int rate_sel_bit(input int nbt_sel);
        return nbt_sel - 1;
    endfunction

endpackage

// File: rtl/log_rd_gate.sv
// Processor readback stage: registers the request and address while the
// logger is idle, then delays the enable by one cycle to form read-valid.
module log_rd_gate
    import log_pkg::*;
#(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_allow,
    input  logic          i_rd_req,
    input  logic [AW-1:0] i_rd_adrs,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_adrs,
    output logic          o_rd_valid
);

    // [0] = RAM read enable, [1] = data valid on the RAM output
    logic [1:0]    r_vld_pipe;
    logic [AW-1:0] r_rd_adrs;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_vld_pipe <= '0;
            r_rd_adrs  <= '0;
        end else begin
            // Valid follows enable unconditionally so an in-flight read completes.
            r_vld_pipe <= {r_vld_pipe[0], i_rd_req & i_allow};
            if (i_allow)
                r_rd_adrs <= i_rd_adrs;
        end
    end

    assign o_rd_en    = r_vld_pipe[0];
    assign o_rd_valid = r_vld_pipe[1];
    assign o_rd_adrs  = r_rd_adrs;

endmodule

// File: rtl/log_capture_ctrl.sv
// Capture sequencer for the sample logger: start edge, settling delay,
// one RAM write per selected rate strobe until full or stopped.
module log_capture_ctrl
    import log_pkg::*;
#(
    parameter int RAM_DEPTH = RAM_DEPTH_DEF,
    parameter int N_DELAY   = N_DELAY_DEF,
    parameter int NBT_SEL   = NBT_SEL_DEF,
    localparam int AW       = $clog2(RAM_DEPTH)
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [NBT_SEL-1:0] i_data_sel,
    input  logic               i_rate_tick_1,
    input  logic               i_rate_tick_2,
    input  logic               i_rd_req,
    input  logic [AW-1:0]      i_rd_adrs,
    output logic               o_we,
    output logic [AW-1:0]      o_wr_adrs,
    output logic [NBT_SEL-1:0] o_data_sel,
    output logic               o_rd_en,
    output logic [AW-1:0]      o_rd_adrs,
    output logic               o_rd_valid,
    output logic               o_busy,
    output logic               o_full,
    output logic [AW:0]        o_count,
    output logic [1:0]         o_state
);

    localparam int SEL_BIT = rate_sel_bit(NBT_SEL);
    localparam int DW      = (N_DELAY > 1) ? $clog2(N_DELAY) : 1;
    localparam logic [DW-1:0] DLY_INIT = (N_DELAY > 0) ? DW'(N_DELAY - 1) : '0;

    state_t             r_state, w_state_nxt;
    logic               r_start_q;
    logic [DW-1:0]      r_dly_cnt;
    logic [AW-1:0]      r_ptr;
    logic [AW-1:0]      r_wr_adrs;
    logic [AW:0]        r_count;
    logic               r_full;
    logic               r_we;
    logic               r_busy;
    logic [NBT_SEL-1:0] r_data_sel;

    logic w_start_re, w_idle, w_tick, w_last, w_wr, w_load, w_busy_nxt;

    assign w_start_re = i_start & ~r_start_q;
    assign w_idle     = (r_state == ST_IDLE) | (r_state == ST_DONE);
    assign w_tick     = r_data_sel[SEL_BIT] ? i_rate_tick_2 : i_rate_tick_1;
    assign w_last     = (r_ptr == AW'(RAM_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE:
                if (w_start_re)
                    w_state_nxt = (N_DELAY == 0) ? ST_CAPTURE : ST_DELAY;
            ST_DELAY:
                if (i_stop)
                    w_state_nxt = ST_DONE;
                else if (r_dly_cnt == '0)
                    w_state_nxt = ST_CAPTURE;
            ST_CAPTURE:
                if (i_stop)
                    w_state_nxt = ST_DONE;
                else if (w_tick & w_last)
                    w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A stop in the same cycle as a tick drops that tick.
    always_comb begin
        w_load     = w_start_re & w_idle;
        w_wr       = (r_state == ST_CAPTURE) & ~i_stop & w_tick;
        w_busy_nxt = (w_state_nxt == ST_DELAY) | (w_state_nxt == ST_CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_start_q  <= i_start;
            r_dly_cnt  <= '0;
            r_ptr      <= '0;
            r_wr_adrs  <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_data_sel <= '0;
        end else begin
            r_start_q <= i_start;
            r_we      <= w_wr;
            r_busy    <= w_busy_nxt;
            if (w_load) begin
                r_data_sel <= i_data_sel;
                r_ptr      <= '0;
                r_count    <= '0;
                r_full     <= 1'b0;
                r_dly_cnt  <= DLY_INIT;
            end else if (w_wr) begin
                r_wr_adrs <= r_ptr;
                r_ptr     <= r_ptr + AW'(1);
                r_count   <= r_count + (AW+1)'(1);
                if (w_last)
                    r_full <= 1'b1;
            end else if (r_state == ST_DELAY && r_dly_cnt != '0) begin
                r_dly_cnt <= r_dly_cnt - DW'(1);
            end
        end
    end

    log_rd_gate #(.AW(AW)) u_rd_gate (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_allow    (w_idle),
        .i_rd_req   (i_rd_req),
        .i_rd_adrs  (i_rd_adrs),
        .o_rd_en    (o_rd_en),
        .o_rd_adrs  (o_rd_adrs),
        .o_rd_valid (o_rd_valid)
    );

    assign o_we       = r_we;
    assign o_wr_adrs  = r_wr_adrs;
    assign o_data_sel = r_data_sel;
    assign o_busy     = r_busy;
    assign o_full     = r_full;
    assign o_count    = r_count;
    assign o_state    = r_state;

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Directed bench for log_capture_ctrl with a 16-word RAM and a 250-cycle
// settling delay, plus a zero-delay instance for the no-wait case.
module tb_log_capture_ctrl;

    localparam int RAM_DEPTH = 16;
    localparam int AW        = 4;

    logic          clk = 1'b0;
    logic          i_reset, i_start, i_stop, i_rate_tick_1, i_rate_tick_2, i_rd_req;
    logic [2:0]    i_data_sel;
    logic [AW-1:0] i_rd_adrs;

    logic          o_we, o_rd_en, o_rd_valid, o_busy, o_full;
    logic [AW-1:0] o_wr_adrs, o_rd_adrs;
    logic [2:0]    o_data_sel;
    logic [AW:0]   o_count;
    logic [1:0]    o_state;

    logic          z_we, z_rd_en, z_rd_valid, z_busy, z_full;
    logic [AW-1:0] z_wr_adrs, z_rd_adrs;
    logic [2:0]    z_data_sel;
    logic [AW:0]   z_count;
    logic [1:0]    z_state;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    log_capture_ctrl #(.RAM_DEPTH(RAM_DEPTH), .N_DELAY(250), .NBT_SEL(3)) dut (
        .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
        .i_data_sel(i_data_sel), .i_rate_tick_1(i_rate_tick_1), .i_rate_tick_2(i_rate_tick_2),
        .i_rd_req(i_rd_req), .i_rd_adrs(i_rd_adrs),
        .o_we(o_we), .o_wr_adrs(o_wr_adrs), .o_data_sel(o_data_sel),
        .o_rd_en(o_rd_en), .o_rd_adrs(o_rd_adrs), .o_rd_valid(o_rd_valid),
        .o_busy(o_busy), .o_full(o_full), .o_count(o_count), .o_state(o_state)
    );

    log_capture_ctrl #(.RAM_DEPTH(RAM_DEPTH), .N_DELAY(0), .NBT_SEL(3)) dut_nodly (
        .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
        .i_data_sel(i_data_sel), .i_rate_tick_1(i_rate_tick_1), .i_rate_tick_2(i_rate_tick_2),
        .i_rd_req(i_rd_req), .i_rd_adrs(i_rd_adrs),
        .o_we(z_we), .o_wr_adrs(z_wr_adrs), .o_data_sel(z_data_sel),
        .o_rd_en(z_rd_en), .o_rd_adrs(z_rd_adrs), .o_rd_valid(z_rd_valid),
        .o_busy(z_busy), .o_full(z_full), .o_count(z_count), .o_state(z_state)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] sel);
        i_data_sel = sel;
        i_start    = 1'b1;
        step();
        i_start    = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] st);
        int n = 0;
        while (o_state != st && n < 400) begin
            step();
            n++;
        end
        chk("wait_state", {30'd0, o_state}, {30'd0, st});
    endtask

    initial begin
        int n;
        int nwe;
        int bad;
        i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_data_sel = 3'b000;
        i_rate_tick_1 = 1'b0; i_rate_tick_2 = 1'b0; i_rd_req = 1'b0; i_rd_adrs = '0;
        repeat (3) step();
        chk("rst_state", o_state, 0);
        chk("rst_we", o_we, 0);
        chk("rst_count", o_count, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_full", o_full, 0);
        chk("rst_rd_en", o_rd_en, 0);
        chk("rst_rd_valid", o_rd_valid, 0);
        chk("rst_data_sel", o_data_sel, 0);
        i_reset = 1'b0;
        step();

        // 1: settling delay length, rate_1 ticks every 4 cycles
        do_start(3'b000);
        chk("t1_state_delay", o_state, 1);
        chk("t1_busy", o_busy, 1);
        chk("t1_nodly_capture", z_state, 2);
        n = 1;
        step();
        while (o_state == 2'd1 && n < 400) begin
            n++;
            step();
        end
        chk("t1_delay_len", n, 250);
        chk("t1_state_capture", o_state, 2);
        for (int k = 0; k < 3; k++) begin
            i_rate_tick_1 = 1'b1; i_rate_tick_2 = 1'b0;
            step();
            chk("t1_we", o_we, 1);
            chk("t1_adrs", o_wr_adrs, k);
            i_rate_tick_1 = 1'b0; i_rate_tick_2 = 1'b1;
            nwe = 0;
            repeat (3) begin step(); nwe += o_we; end
            chk("t1_quiet", nwe, 0);
        end
        i_rate_tick_2 = 1'b0;
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        chk("t1_stop_state", o_state, 3);
        chk("t1_count", o_count, 3);

        // 2: fill the RAM from rate_2
        do_start(3'b100);
        i_rate_tick_2 = 1'b1;
        wait_state(2'd2);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (o_we !== 1'b1 || o_wr_adrs !== AW'(i)) bad++;
        end
        chk("t2_writes", bad, 0);
        chk("t2_state", o_state, 3);
        chk("t2_full", o_full, 1);
        chk("t2_count", o_count, 16);
        chk("t2_data_sel", o_data_sel, 4);
        chk("t2_busy", o_busy, 0);
        nwe = 0;
        repeat (3) begin step(); nwe += o_we; end
        chk("t2_no_overwrite", nwe, 0);
        i_rate_tick_2 = 1'b0;

        // 4a: readback while DONE
        i_rd_req = 1'b1; i_rd_adrs = 4'd7;
        step();
        i_rd_req = 1'b0; i_rd_adrs = 4'd0;
        chk("t4_rd_en", o_rd_en, 1);
        chk("t4_rd_adrs", o_rd_adrs, 7);
        chk("t4_valid_early", o_rd_valid, 0);
        step();
        chk("t4_rd_valid", o_rd_valid, 1);
        chk("t4_rd_en_drop", o_rd_en, 0);

        // 3: stop after 5 writes, in the same cycle as a tick
        do_start(3'b000);
        i_rate_tick_1 = 1'b1;
        wait_state(2'd2);
        nwe = 0;
        repeat (5) begin step(); nwe += o_we; end
        chk("t3_writes", nwe, 5);
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        chk("t3_state", o_state, 3);
        chk("t3_no_6th_we", o_we, 0);
        chk("t3_count", o_count, 5);
        chk("t3_full", o_full, 0);

        // 6 + 4b: read blocked during capture, reset at pointer 9
        do_start(3'b000);
        wait_state(2'd2);
        i_rd_req = 1'b1; i_rd_adrs = 4'd7;
        bad = 0;
        repeat (9) begin
            step();
            bad += int'(o_rd_en) + int'(o_rd_valid);
        end
        chk("t4_rd_blocked", bad, 0);
        chk("t6_last_adrs", o_wr_adrs, 8);
        chk("t6_count9", o_count, 9);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        i_rd_req = 1'b0;
        chk("t6_rst_we", o_we, 0);
        chk("t6_rst_state", o_state, 0);
        chk("t6_rst_count", o_count, 0);
        do_start(3'b000);
        wait_state(2'd2);
        step();
        chk("t6_restart_we", o_we, 1);
        chk("t6_restart_adrs", o_wr_adrs, 0);
        i_rate_tick_1 = 1'b0;
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;

        // 5: start held through reset, then start+stop together in IDLE
        i_start = 1'b1;
        i_reset = 1'b1;
        repeat (2) step();
        i_reset = 1'b0;
        repeat (5) step();
        chk("t5_held_idle", o_state, 0);
        i_start = 1'b0;
        step();
        i_start = 1'b1; i_stop = 1'b1;
        step();
        chk("t5_start_wins", o_state, 1);
        i_start = 1'b0; i_stop = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
